snake_reg_ctrl: RTL and testbench

Write-port controller for the 109-entry snake game register file: cells 0..99 are 2-bit, and indices 100..108 are 32-bit game registers. The register file has one write port (index, value, enable). This block shares that port between two requesters: the processor store path, and an internal board-clear/init engine that sweeps the register file on a new game. It sits between the processor memory-mapped store decode and the snake register file.

---
 rtl/snake_reg_ctrl_if.sv | 33 +++
 rtl/snake_reg_ctrl.sv | 173 +++++++++++++++++
 tb/tb_snake_reg_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_reg_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : snake_reg_ctrl_if
// Description : Bundles the processor store handshake, the board-clear
//               control/status lines and the register-file write port that
//               meet at snake_reg_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface snake_reg_ctrl_if;
  logic        cpu_req;
  logic [31:0] cpu_index;
  logic [31:0] cpu_data;
  logic        cpu_ack;
  logic        clear_start;
  logic        busy;
  logic        clear_done;
  logic [31:0] reg_index;
  logic [31:0] reg_value;
  logic        reg_enable;

  // Processor / game-control side
  modport master (
    output cpu_req, cpu_index, cpu_data, clear_start,
    input  cpu_ack, busy, clear_done, reg_index, reg_value, reg_enable
  );

  // Controller side
  modport slave (
    input  cpu_req, cpu_index, cpu_data, clear_start,
    output cpu_ack, busy, clear_done, reg_index, reg_value, reg_enable
  );
endinterface
`default_nettype wire

// File: rtl/snake_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snake_reg_ctrl
// Description : Shares the snake register-file write port between the
//               processor store path and a board-clear/init sweep engine,
//               with round-robin arbitration when both want the port.
//               Optional macro SNAKE_CTRL_INIT_REGS_EN: when defined the
//               sweep also initialises game registers 100..LAST_INDEX;
//               when undefined only the board cells are cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_reg_ctrl #(
  parameter int          NUM_CELLS      = 100,
  parameter int          LAST_INDEX     = 108,
  parameter logic [31:0] HEAD1_POS_INIT = 32'd11,
  parameter logic [31:0] HEAD2_POS_INIT = 32'd88,
  parameter logic [31:0] LEN_INIT       = 32'd1,
  parameter logic [31:0] APPLE_INIT     = 32'd55
) (
  input wire logic        clock,
  input wire logic        reset,
  snake_reg_ctrl_if.slave bus
);

  localparam logic [1:0]  c_st_idle   = 2'd0;
  localparam logic [1:0]  c_st_cells  = 2'd1;
  localparam logic [1:0]  c_st_regs   = 2'd2;
  localparam logic [1:0]  c_st_fin    = 2'd3;

  localparam logic [6:0]  c_last_cell = 7'(NUM_CELLS - 1);
  localparam logic [6:0]  c_last_reg  = 7'(LAST_INDEX);
  localparam logic [31:0] c_max_index = 32'(LAST_INDEX);

  logic [1:0]  r_state;
  logic [6:0]  r_count;
  logic        r_last_eng;    // 1: engine won the previous grant, 0: CPU
  logic        r_cpu_ack;
  logic        r_busy;
  logic        r_clear_done;
  logic [31:0] r_reg_index;
  logic [31:0] r_reg_value;
  logic        r_reg_enable;

  logic [1:0]  w_state_nxt;
  logic [6:0]  w_count_nxt;
  logic        w_cpu_cont;
  logic        w_eng_cont;
  logic        w_grant_cpu;
  logic        w_grant_eng;
  logic        w_cpu_ack_nxt;
  logic        w_busy_nxt;
  logic        w_clear_done_nxt;
  logic [31:0] w_reg_index_nxt;
  logic [31:0] w_reg_value_nxt;
  logic        w_reg_enable_nxt;

  // Init value written into game register idx during the register sweep
  function automatic logic [31:0] f_init_value(input logic [6:0] idx);
    case (idx)
      7'd100:  f_init_value = HEAD1_POS_INIT;
      7'd101:  f_init_value = HEAD2_POS_INIT;
      7'd102:  f_init_value = LEN_INIT;
      7'd103:  f_init_value = LEN_INIT;
      7'd107:  f_init_value = APPLE_INIT;
      default: f_init_value = 32'd0;
    endcase
  endfunction

  // A request being acknowledged this cycle is not a new request
  assign w_cpu_cont  = bus.cpu_req & ~r_cpu_ack;
  assign w_eng_cont  = (r_state == c_st_cells) | (r_state == c_st_regs);
  // Round-robin: on a tie the side that did not win last time goes first
  assign w_grant_cpu = w_cpu_cont & (~w_eng_cont | r_last_eng);
  assign w_grant_eng = w_eng_cont & (~w_cpu_cont | ~r_last_eng);

  // State, sweep counter, arbitration history and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= c_st_idle;
      r_count      <= 7'd0;
      r_last_eng   <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_busy       <= 1'b0;
      r_clear_done <= 1'b0;
      r_reg_index  <= 32'd0;
      r_reg_value  <= 32'd0;
      r_reg_enable <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      if (w_grant_cpu) begin
        r_last_eng <= 1'b0;
      end else if (w_grant_eng) begin
        r_last_eng <= 1'b1;
      end
      r_cpu_ack    <= w_cpu_ack_nxt;
      r_busy       <= w_busy_nxt;
      r_clear_done <= w_clear_done_nxt;
      r_reg_index  <= w_reg_index_nxt;
      r_reg_value  <= w_reg_value_nxt;
      r_reg_enable <= w_reg_enable_nxt;
    end
  end

  // Sweep sequencing: counter advances only on engine grants, stops at terminal count
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      c_st_idle: begin
        if (bus.clear_start) begin
          w_state_nxt = c_st_cells;
          w_count_nxt = 7'd0;
        end
      end
      c_st_cells: begin
        if (w_grant_eng) begin
          if (r_count == c_last_cell) begin
`ifdef SNAKE_CTRL_INIT_REGS_EN
            w_state_nxt = c_st_regs;
            w_count_nxt = 7'(NUM_CELLS);
`else
            w_state_nxt = c_st_fin;
`endif
          end else begin
            w_count_nxt = r_count + 7'd1;
          end
        end
      end
      c_st_regs: begin
        if (w_grant_eng) begin
          if (r_count == c_last_reg) begin
            w_state_nxt = c_st_fin;
          end else begin
            w_count_nxt = r_count + 7'd1;
          end
        end
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Next values of the registered outputs; write port holds when nobody is granted
  always_comb begin
    w_cpu_ack_nxt    = w_grant_cpu;
    w_busy_nxt       = (w_state_nxt != c_st_idle);
    w_clear_done_nxt = (r_state == c_st_fin);
    w_reg_index_nxt  = r_reg_index;
    w_reg_value_nxt  = r_reg_value;
    w_reg_enable_nxt = 1'b0;
    if (w_grant_cpu) begin
      w_reg_index_nxt  = bus.cpu_index;
      w_reg_value_nxt  = bus.cpu_data;
      // Out-of-range stores are acknowledged but never reach the register file
      w_reg_enable_nxt = (bus.cpu_index <= c_max_index);
    end else if (w_grant_eng) begin
      w_reg_index_nxt  = {25'd0, r_count};
      w_reg_value_nxt  = (r_state == c_st_regs) ? f_init_value(r_count) : 32'd0;
      w_reg_enable_nxt = 1'b1;
    end
  end

  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.busy       = r_busy;
  assign bus.clear_done = r_clear_done;
  assign bus.reg_index  = r_reg_index;
  assign bus.reg_value  = r_reg_value;
  assign bus.reg_enable = r_reg_enable;

endmodule
`default_nettype wire

// File: tb/tb_snake_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_reg_ctrl
// Description : Self-checking bench for snake_reg_ctrl. Expected register
//               file writes are queued when stimulus is applied (separate
//               queues for CPU and engine writes) and popped as the DUT
//               produces them. Honours SNAKE_CTRL_INIT_REGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_reg_ctrl;

`ifdef SNAKE_CTRL_INIT_REGS_EN
  localparam int c_sweep_len = 109;
`else
  localparam int c_sweep_len = 100;
`endif
  localparam int c_num_cells = 100;
  localparam int c_timeout   = 400;

  typedef struct {
    logic [31:0] idx;
    logic [31:0] val;
    logic        en;
  } wr_t;

  logic clock;
  logic reset;

  snake_reg_ctrl_if bus();

  snake_reg_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int  checks;
  int  errors;
  int  done_count;
  int  last_eng_idx;
  wr_t eng_q[$];
  wr_t cpu_q[$];

  // Expected init value for game register i
  function automatic int f_exp_init(input int i);
    case (i)
      100: return 11;
      101: return 88;
      102: return 1;
      103: return 1;
      107: return 55;
      default: return 0;
    endcase
  endfunction

  // Queue the engine writes of one full uncontended sweep
  task automatic push_sweep();
    for (int i = 0; i < c_sweep_len; i++) begin
      eng_q.push_back('{idx: 32'(i), val: (i < c_num_cells) ? 32'd0 : 32'(f_exp_init(i)), en: 1'b1});
    end
  endtask

  // Advance one cycle and score whatever the DUT put on the write port
  task automatic step();
    wr_t e;
    @(posedge clock);
    @(negedge clock);
    if (bus.clear_done === 1'b1) done_count++;
    if (bus.cpu_ack === 1'b1) begin
      checks++;
      if (cpu_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_unexpected_ack got idx=%0d en=%0b, no CPU write pending", bus.reg_index, bus.reg_enable);
      end else begin
        e = cpu_q.pop_front();
        if (bus.reg_enable !== e.en || (e.en && (bus.reg_index !== e.idx || bus.reg_value !== e.val))) begin
          errors++;
          $display("FAIL cpu_write got en=%0b idx=%0d val=%0d expected en=%0b idx=%0d val=%0d",
                   bus.reg_enable, bus.reg_index, bus.reg_value, e.en, e.idx, e.val);
        end
      end
    end else if (bus.reg_enable !== 1'b0) begin
      checks++;
      if (eng_q.size() == 0) begin
        errors++;
        $display("FAIL eng_unexpected_write got en=%0b idx=%0d val=%0d", bus.reg_enable, bus.reg_index, bus.reg_value);
      end else begin
        e = eng_q.pop_front();
        if (bus.reg_index !== e.idx || bus.reg_value !== e.val) begin
          errors++;
          $display("FAIL eng_write got idx=%0d val=%0d expected idx=%0d val=%0d",
                   bus.reg_index, bus.reg_value, e.idx, e.val);
        end
      end
      last_eng_idx = int'(bus.reg_index);
    end
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    bus.cpu_req     = 1'b0;
    bus.cpu_index   = 32'd0;
    bus.cpu_data    = 32'd0;
    bus.clear_start = 1'b0;
    step();
    step();
    checks++;
    if ({bus.cpu_ack, bus.busy, bus.clear_done, bus.reg_enable, bus.reg_index, bus.reg_value} !== 68'd0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%0b busy=%0b done=%0b en=%0b idx=%0d val=%0d expected all 0",
               bus.cpu_ack, bus.busy, bus.clear_done, bus.reg_enable, bus.reg_index, bus.reg_value);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({bus.cpu_ack, bus.busy, bus.clear_done, bus.reg_enable} !== 4'd0) begin
      errors++;
      $display("FAIL idle_after_reset got ack=%0b busy=%0b done=%0b en=%0b expected 0",
               bus.cpu_ack, bus.busy, bus.clear_done, bus.reg_enable);
    end
  endtask

  // Single CPU store from idle; exp_en=0 for out-of-range indices
  task automatic test_cpu_write(input logic [31:0] idx, input logic [31:0] data, input logic exp_en);
    int lat;
    cpu_q.push_back('{idx: idx, val: data, en: exp_en});
    bus.cpu_index = idx;
    bus.cpu_data  = data;
    bus.cpu_req   = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (bus.cpu_ack !== 1'b1 && lat < 10);
    bus.cpu_req = 1'b0;
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL cpu_ack_latency idx=%0d got %0d cycles expected 1", idx, lat);
    end
    step();
    checks++;
    if (bus.cpu_ack !== 1'b0 || bus.reg_enable !== 1'b0) begin
      errors++;
      $display("FAIL cpu_single_pulse got ack=%0b en=%0b expected 0 0", bus.cpu_ack, bus.reg_enable);
    end
  endtask

  // Each new request is presented the moment the previous one is acked
  task automatic test_back_to_back();
    int n;
    int cyc;
    for (int i = 0; i < 4; i++) cpu_q.push_back('{idx: 32'(104 + i), val: 32'(500 + i), en: 1'b1});
    bus.cpu_index = 32'd104;
    bus.cpu_data  = 32'd500;
    bus.cpu_req   = 1'b1;
    n   = 0;
    cyc = 0;
    while (n < 4 && cyc < 20) begin
      step();
      cyc++;
      if (bus.cpu_ack === 1'b1) begin
        n++;
        if (n < 4) begin
          bus.cpu_index = 32'(104 + n);
          bus.cpu_data  = 32'(500 + n);
        end else begin
          bus.cpu_req = 1'b0;
        end
      end
    end
    bus.cpu_req = 1'b0;
    checks++;
    if (n !== 4 || cyc !== 7) begin
      errors++;
      $display("FAIL back_to_back got %0d acks in %0d cycles expected 4 in 7", n, cyc);
    end
    step();
  endtask

  // Full sweep with optional CPU stores starting after engine index cpu_at
  // and a stray clear_start while busy and again in the final state
  task automatic test_sweep(input int n_cpu, input int cpu_at);
    int cyc;
    int sent;
    int done_cyc;
    push_sweep();
    done_count   = 0;
    last_eng_idx = -1;
    done_cyc     = 0;
    sent         = 0;
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    cyc = 1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %0b expected 1", bus.busy);
    end
    while (cyc < c_timeout) begin
      if (bus.clear_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (bus.cpu_ack === 1'b1) bus.cpu_req = 1'b0;
      if (bus.cpu_req === 1'b0 && sent < n_cpu && last_eng_idx >= cpu_at) begin
        cpu_q.push_back('{idx: 32'd105, val: 32'(3 + sent), en: 1'b1});
        bus.cpu_index = 32'd105;
        bus.cpu_data  = 32'(3 + sent);
        bus.cpu_req   = 1'b1;
        sent++;
      end
      bus.clear_start = (cyc == 50) ||
                        (bus.reg_enable === 1'b1 && bus.cpu_ack === 1'b0 && last_eng_idx == c_sweep_len - 1);
      step();
      cyc++;
    end
    bus.clear_start = 1'b0;
    bus.cpu_req     = 1'b0;
    checks++;
    if (done_cyc !== c_sweep_len + 2 + n_cpu) begin
      errors++;
      $display("FAIL clear_done_cycle got %0d expected %0d", done_cyc, c_sweep_len + 2 + n_cpu);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_at_done got %0b expected 0", bus.busy);
    end
    checks++;
    if (last_eng_idx !== c_sweep_len - 1) begin
      errors++;
      $display("FAIL last_engine_index got %0d expected %0d", last_eng_idx, c_sweep_len - 1);
    end
    checks++;
    if (eng_q.size() != 0 || cpu_q.size() != 0 || sent != n_cpu) begin
      errors++;
      $display("FAIL writes_outstanding got eng=%0d cpu=%0d sent=%0d expected 0 0 %0d",
               eng_q.size(), cpu_q.size(), sent, n_cpu);
    end
    repeat (4) step();
    checks++;
    if (done_count !== 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_clear_done got pulses=%0d busy=%0b expected 1 0", done_count, bus.busy);
    end
    eng_q.delete();
    cpu_q.delete();
  endtask

  // Reset while the engine counter is at 57
  task automatic test_reset_mid_sweep();
    int n;
    push_sweep();
    done_count   = 0;
    last_eng_idx = -1;
    bus.clear_start = 1'b1;
    step();
    bus.clear_start = 1'b0;
    n = 0;
    while (last_eng_idx != 56 && n < c_timeout) begin
      step();
      n++;
    end
    checks++;
    if (last_eng_idx !== 56) begin
      errors++;
      $display("FAIL reach_index_56 got %0d expected 56", last_eng_idx);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({bus.busy, bus.reg_enable, bus.clear_done, bus.cpu_ack} !== 4'd0 || bus.reg_index !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_sweep got busy=%0b en=%0b done=%0b ack=%0b idx=%0d expected 0",
               bus.busy, bus.reg_enable, bus.clear_done, bus.cpu_ack, bus.reg_index);
    end
    eng_q.delete();
    reset = 1'b1;
    repeat (5) step();
    checks++;
    if (done_count !== 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abandoned_sweep got pulses=%0d busy=%0b expected 0 0", done_count, bus.busy);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    done_count   = 0;
    last_eng_idx = -1;
    test_reset();
    test_cpu_write(32'd102, 32'd7, 1'b1);
    test_cpu_write(32'd200, 32'd9, 1'b0);
    test_back_to_back();
    test_sweep(0, 0);
    test_sweep(3, 40);
    test_reset_mid_sweep();
    test_sweep(0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
